// File: rtl/uart_rx_frame_ctrl_if.sv
// UART RX frame controller bundle: serial line, parity-checker link, RX word output.
// master = frame controller side, slave = line / checker / consumer side.
interface uart_rx_frame_ctrl_if #(
    parameter int width = 8
);
    logic             RX_IN;
    logic             PAR_EN;
    logic             par_error;
    logic             EN;
    logic             Par_chk_en;
    logic             Sampled_Parity_bit;
    logic [width-1:0] P_Data;
    logic             data_valid;
    logic             framing_error;
    logic             parity_fail;

    modport master (
        input  RX_IN, PAR_EN, par_error,
        output EN, Par_chk_en, Sampled_Parity_bit, P_Data,
        output data_valid, framing_error, parity_fail
    );

    modport slave (
        output RX_IN, PAR_EN, par_error,
        input  EN, Par_chk_en, Sampled_Parity_bit, P_Data,
        input  data_valid, framing_error, parity_fail
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame controller: start detect, mid-bit majority vote, LSB-first
// deserialize, parity handoff to checker, stop check. Ports: clk, rst_n, bus (master).
module uart_rx_frame_ctrl #(
    parameter int width    = 8,
    parameter int PRESCALE = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    uart_rx_frame_ctrl_if.master  bus
);
    localparam int ECW = $clog2(PRESCALE);
    localparam int BCW = $clog2(width) + 1;

    localparam logic [ECW-1:0] EC_LAST = ECW'(PRESCALE - 1);
    localparam logic [ECW-1:0] EC_S0   = ECW'(PRESCALE / 2 - 1);
    localparam logic [ECW-1:0] EC_S1   = ECW'(PRESCALE / 2);
    localparam logic [ECW-1:0] EC_S2   = ECW'(PRESCALE / 2 + 1);
    localparam logic [BCW-1:0] BC_LAST = BCW'(width - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state_q;
    logic [ECW-1:0]   edge_cnt_q;
    logic [BCW-1:0]   bit_cnt_q;
    logic [1:0]       smp_q;
    logic             sampled_bit_q;
    logic             par_en_q;
    logic [width-1:0] p_data_q;
    logic [width-1:0] p_data_d;
    logic             spb_q;
    logic             en_q;
    logic             pce_q;
    logic             dv_q;
    logic             fe_q;
    logic             pf_q;
    logic             end_of_bit;
    logic             vote_d;

    assign end_of_bit = (edge_cnt_q == EC_LAST);
    assign p_data_d   = {sampled_bit_q, p_data_q[width-1:1]};
    // third capture is the live line; vote lands well before end of bit
    assign vote_d     = (smp_q[0] & smp_q[1]) |
                        (smp_q[0] & bus.RX_IN) |
                        (smp_q[1] & bus.RX_IN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_q         <= '0;
            sampled_bit_q <= 1'b0;
        end else if (state_q != IDLE) begin
            if (edge_cnt_q == EC_S0) smp_q[0] <= bus.RX_IN;
            if (edge_cnt_q == EC_S1) smp_q[1] <= bus.RX_IN;
            if (edge_cnt_q == EC_S2) sampled_bit_q <= vote_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            par_en_q   <= 1'b0;
            p_data_q   <= '0;
            spb_q      <= 1'b0;
            en_q       <= 1'b0;
            pce_q      <= 1'b0;
            dv_q       <= 1'b0;
            fe_q       <= 1'b0;
            pf_q       <= 1'b0;
        end else begin
            pce_q <= 1'b0;
            dv_q  <= 1'b0;
            fe_q  <= 1'b0;
            pf_q  <= 1'b0;
            // power-of-two prescale: natural wrap at PRESCALE-1
            edge_cnt_q <= edge_cnt_q + ECW'(1);
            case (state_q)
                IDLE: begin
                    edge_cnt_q <= '0;
                    if (!bus.RX_IN) begin
                        // detection cycle is tick 0 of the start bit
                        state_q    <= START;
                        edge_cnt_q <= ECW'(1);
                        par_en_q   <= bus.PAR_EN;
                        en_q       <= 1'b1;
                    end
                end
                START: begin
                    if (end_of_bit) begin
                        if (sampled_bit_q) begin
                            state_q <= IDLE;
                            en_q    <= 1'b0;
                        end else begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                end
                DATA: begin
                    if (end_of_bit) begin
                        p_data_q  <= p_data_d;
                        bit_cnt_q <= bit_cnt_q + BCW'(1);
                        if (bit_cnt_q == BC_LAST)
                            state_q <= par_en_q ? PARITY : STOP;
                    end
                end
                PARITY: begin
                    if (end_of_bit) begin
                        spb_q   <= sampled_bit_q;
                        pce_q   <= 1'b1;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (end_of_bit) begin
                        state_q <= IDLE;
                        en_q    <= 1'b0;
                        if (!sampled_bit_q)
                            fe_q <= 1'b1;
                        else if (par_en_q && bus.par_error)
                            pf_q <= 1'b1;
                        else
                            dv_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.EN                 = en_q;
    assign bus.Par_chk_en         = pce_q;
    assign bus.Sampled_Parity_bit = spb_q;
    assign bus.P_Data             = p_data_q;
    assign bus.data_valid         = dv_q;
    assign bus.framing_error      = fe_q;
    assign bus.parity_fail        = pf_q;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Bench for uart_rx_frame_ctrl: frames driven bit-serially, expected results
// queued at stimulus time and matched when result pulses appear.
module tb_uart_rx_frame_ctrl;
    localparam int W  = 8;
    localparam int PS = 8;

    localparam logic [2:0] K_DV = 3'b001;
    localparam logic [2:0] K_FE = 3'b010;
    localparam logic [2:0] K_PF = 3'b100;

    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        int         t0;
        int         lat;
        int         npce;
        logic       pbit;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_pass;
    int   pce_seen;
    int   prev_dv;
    int   last_dv;
    exp_t exp_q[$];

    uart_rx_frame_ctrl_if #(.width(W)) bus ();

    uart_rx_frame_ctrl #(.width(W), .PRESCALE(PS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // even-mode parity checker model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bus.par_error <= 1'b0;
        else if (!bus.EN)
            bus.par_error <= 1'b0;
        else if (bus.Par_chk_en)
            bus.par_error <= (^bus.P_Data) ^ bus.Sampled_Parity_bit;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, exp, cyc);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.Par_chk_en) begin
                pce_seen++;
                if (exp_q.size() == 0) begin
                    chk("pce_unexpected", 32'd1, 32'd0);
                end else begin
                    chk("pce_lat", cyc - exp_q[0].t0, 32'((1 + W + 1) * PS));
                    chk("pce_pbit", {31'd0, bus.Sampled_Parity_bit},
                        {31'd0, exp_q[0].pbit});
                end
            end
            if (bus.data_valid | bus.framing_error | bus.parity_fail) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_result", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("kind", {29'd0, bus.parity_fail, bus.framing_error,
                        bus.data_valid}, {29'd0, e.kind});
                    chk("lat", cyc - e.t0, e.lat);
                    chk("pce_cnt", pce_seen, e.npce);
                    if (e.kind == K_DV) begin
                        chk("p_data", {24'd0, bus.P_Data}, {24'd0, e.data});
                        prev_dv = last_dv;
                        last_dv = cyc;
                    end
                end
                pce_seen = 0;
            end
        end
    end

    task automatic send(input logic [7:0] d, input logic par, input logic pbit,
                        input logic stop, input int flip_idx, input int flip_off);
        logic bits [0:10];
        int   nb;
        exp_t e;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        bits[9]  = par ? pbit : stop;
        bits[10] = stop;
        nb = par ? 11 : 10;
        e.data = d;
        e.t0   = cyc;
        e.lat  = nb * PS;
        e.npce = par ? 1 : 0;
        e.pbit = pbit;
        if (!stop)                    e.kind = K_FE;
        else if (par && (pbit != ^d)) e.kind = K_PF;
        else                          e.kind = K_DV;
        exp_q.push_back(e);
        bus.PAR_EN = par;
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < PS; j++) begin
                bus.RX_IN = bits[b] ^ ((b == flip_idx) && (j == flip_off));
                @(negedge clk);
            end
        end
    endtask

    function automatic logic [31:0] outs();
        return {18'd0, bus.EN, bus.Par_chk_en, bus.Sampled_Parity_bit,
                bus.P_Data, bus.data_valid, bus.framing_error, bus.parity_fail};
    endfunction

    initial begin
        logic [7:0] part;
        cyc = 0; n_chk = 0; n_pass = 0; pce_seen = 0;
        prev_dv = 0; last_dv = 0;
        bus.RX_IN = 1'b1;
        bus.PAR_EN = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", outs(), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_outs", outs(), 32'd0);

        send(8'hA5, 1'b0, 1'b0, 1'b1, -1, 0);
        bus.RX_IN = 1'b1;
        repeat (3) @(negedge clk);

        send(8'h3C, 1'b1, 1'b0, 1'b1, -1, 0);
        bus.RX_IN = 1'b1;
        repeat (3) @(negedge clk);

        send(8'h3C, 1'b1, 1'b1, 1'b1, -1, 0);
        bus.RX_IN = 1'b1;
        @(negedge clk);
        chk("en_after_pf", {31'd0, bus.EN}, 32'd0);
        repeat (3) @(negedge clk);

        // framing error, line left low: re-detected then glitch-rejected
        send(8'h55, 1'b0, 1'b0, 1'b0, -1, 0);
        chk("en_after_fe", {31'd0, bus.EN}, 32'd0);
        repeat (2) @(negedge clk);
        bus.RX_IN = 1'b1;
        repeat (12) @(negedge clk);
        chk("en_after_low", {31'd0, bus.EN}, 32'd0);

        send(8'h0F, 1'b0, 1'b0, 1'b1, -1, 0);
        bus.RX_IN = 1'b1;
        repeat (3) @(negedge clk);

        // 2-cycle glitch
        bus.RX_IN = 1'b0;
        @(negedge clk);
        chk("glitch_en_on", {31'd0, bus.EN}, 32'd1);
        @(negedge clk);
        bus.RX_IN = 1'b1;
        repeat (5) @(negedge clk);
        chk("glitch_en_t7", {31'd0, bus.EN}, 32'd1);
        @(negedge clk);
        chk("glitch_en_t8", {31'd0, bus.EN}, 32'd0);
        repeat (3) @(negedge clk);

        // one of three mid-bit samples of data bit 3 flipped
        send(8'h96, 1'b0, 1'b0, 1'b1, 4, 4);
        bus.RX_IN = 1'b1;
        repeat (3) @(negedge clk);

        // reset during data bit 4
        part = 8'hC3;
        bus.PAR_EN = 1'b0;
        bus.RX_IN = 1'b0;
        repeat (PS) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.RX_IN = part[i];
            repeat (PS) @(negedge clk);
        end
        bus.RX_IN = part[4];
        repeat (3) @(negedge clk);
        chk("pre_reset_en", {31'd0, bus.EN}, 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outs", outs(), 32'd0);
        bus.RX_IN = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        send(8'hFF, 1'b0, 1'b0, 1'b1, -1, 0);
        send(8'h00, 1'b0, 1'b0, 1'b1, -1, 0);
        bus.RX_IN = 1'b1;
        repeat (3) @(negedge clk);
        chk("b2b_gap", last_dv - prev_dv, 32'(10 * PS));

        repeat (20) @(negedge clk);
        chk("drain", exp_q.size(), 32'd0);
        chk("final_idle", {31'd0, bus.EN}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/uart_rx_frame_ctrl.md
# uart_rx_frame_ctrl

Receive-side frame controller for the UART RX path.
- Detects the start bit on the oversampled serial line and majority-votes each bit at mid-bit.
- Deserializes the data word LSB-first and captures the parity bit.
- Drives the downstream parity checker with `EN`, `Par_chk_en`, `Sampled_Parity_bit` and `P_Data`, and consumes its registered `par_error`.
- Checks the stop bit and presents one validated word per frame to the RX output interface.

## Interface
- `width`, 8: data bits per frame.
- `PRESCALE`, 8: clk cycles per bit; legal values 8, 16, 32.
- `clk` input 1: oversample clock, PRESCALE ticks per bit.
- `rst_n` input 1: asynchronous active-low reset, one clock domain.
- `RX_IN` input 1: serial line, idle high, already synchronized to clk.
- `PAR_EN` input 1: frame carries a parity bit; latched at start detection.
- `par_error` input 1: registered result from the parity checker, 1 = mismatch.
- `EN` output 1: parity-checker enable; high whenever state ≠ IDLE.
- `Par_chk_en` output 1: one-cycle strobe at the end of the parity bit.
- `Sampled_Parity_bit` output 1: voted parity bit, valid from `Par_chk_en` until the next frame's parity bit.
- `P_Data` output width: deserialized word.
- `data_valid` output 1: one-cycle pulse, good frame, `P_Data` stable.
- `framing_error` output 1: one-cycle pulse, stop bit sampled 0.
- `parity_fail` output 1: one-cycle pulse, `PAR_EN` frame with `par_error`=1 at stop end.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Reset → IDLE.
- `edge_cnt` (log2 PRESCALE bits):
  - Held at 0 in IDLE.
  - Counts 0..PRESCALE-1 and wraps in all other states.
  - "End of bit" means `edge_cnt` == PRESCALE-1.
- `bit_cnt` (log2 width + 1 bits): counts data bits; cleared on entry to DATA.
- Sampler:
  - Captures RX_IN at `edge_cnt` = PRESCALE/2-1, PRESCALE/2 and PRESCALE/2+1.
  - `sampled_bit` = majority of the 3 captures, registered before end of bit.
- IDLE: RX_IN==0 → START, `edge_cnt` ← 1 (the detection cycle counts as tick 0), `PAR_EN` latched.
- START, at end of bit:
  - `sampled_bit`==1 → IDLE (glitch rejected, no outputs).
  - Otherwise → DATA.
- DATA, at end of bit:
  - `P_Data` ← {`sampled_bit`, `P_Data`[width-1:1]} (LSB first), `bit_cnt`++.
  - After bit width-1 → PARITY if latched `PAR_EN`, else STOP.
- PARITY, at end of bit: `Sampled_Parity_bit` ← `sampled_bit`, `Par_chk_en` ← 1 for exactly one cycle, → STOP.
- STOP, at end of bit, → IDLE with exactly one of:
  - `sampled_bit`==0 → `framing_error` pulse, regardless of parity.
  - Else if `PAR_EN` and `par_error` → `parity_fail` pulse.
  - Else → `data_valid` pulse.
- `par_error` is registered by the checker on the `Par_chk_en` cycle. It is stable for ≥ PRESCALE-1 cycles before it is used in STOP.
- IDLE drops `EN`, which clears the checker's `par_error`.
- `P_Data` holds the last word until the first data-bit shift of the next frame.
- No `data_valid` is ever issued for a frame with a framing or parity error.

## Timing
- Reset values:
  - State IDLE, counters 0.
  - `P_Data`=0, `Sampled_Parity_bit`=0.
  - `EN`, `Par_chk_en`, `data_valid`, `framing_error`, `parity_fail` all 0.
- Frame length from the detection cycle: (2 + width + PAR_EN) × PRESCALE cycles.
- Result pulse latency:
  - The result pulse is asserted in the cycle following the last STOP tick.
  - That is (2+width+PAR_EN)×PRESCALE cycles after the detection cycle: 80 for width=8, PAR_EN=0, PRESCALE=8; 88 with parity.
- `Par_chk_en` is asserted (1+width+1)×PRESCALE cycles after detection, for one cycle.
- Back-to-back frames:
  - A new start edge is accepted on the first IDLE cycle after STOP.
  - ≤1 cycle of skew, absorbed by mid-bit sampling.
- `PAR_EN` changes mid-frame have no effect until the next start detection.
- Reset mid-frame: all outputs go to reset values immediately (asynchronous); partial data is discarded; no pulses.
- RX_IN held low in IDLE after a framing error: treated as a new start, with glitch rejection applied.

## Test plan
- `PAR_EN`=0, PRESCALE=8, send 0xA5 with stop=1 → single `data_valid` 80 cycles after detection, `P_Data`=0xA5, no error pulses, `Par_chk_en` never asserted.
- `PAR_EN`=1, send 0x3C with parity bit 0 and the checker in even mode → one `Par_chk_en` pulse with `Sampled_Parity_bit`=0 at cycle 80, `data_valid` at 88, `P_Data`=0x3C.
- `PAR_EN`=1, send 0x3C with parity bit 1 → `parity_fail` pulse at 88, no `data_valid`, `EN` low the next cycle.
- Send 0x55 with stop bit 0 → `framing_error` pulse, no `data_valid`/`parity_fail`, state IDLE; a following frame 0x0F is received correctly.
- RX_IN low for 2 cycles only → no outputs, back in IDLE after 8 cycles. In a data frame, flip one of the three mid-bit samples of bit 3 → `P_Data` still correct.
- Assert `rst_n`=0 during DATA bit 4 → all outputs 0 immediately; after release, two back-to-back frames 0xFF, 0x00 → two `data_valid` pulses 80 cycles apart (±1).
